// File: rtl/otp_rw_ctrl.sv
// Byte read / bit-serial program sequencer for the 8Kx8 OTP macro; all outputs registered.
// Macro pins show the state of the previous cycle, so read ack lands RD_WAIT+3 cycles after req.
module otp_rw_ctrl #(
    parameter int RD_WAIT  = 4,
    parameter int PG_PULSE = 40,
    parameter int PG_GAP   = 4,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        req,
    input  logic        we,
    input  logic [12:0] addr,
    input  logic [7:0]  wdata,
    input  logic        vpp_ok,
    input  logic [1:0]  twlb_cfg,
    input  logic [1:0]  sap_cfg,
    input  logic [7:0]  otp_q,
    output logic        busy,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        err,
    output logic [15:0] otp_a,
    output logic        otp_csb,
    output logic        otp_clk,
    output logic        otp_re,
    output logic        otp_pgm,
    output logic [1:0]  otp_twlb,
    output logic [1:0]  otp_sap
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_SU, S_RD_CLK, S_PG_CHK, S_PG_SU, S_PG_PULSE, S_PG_GAP, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [12:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [2:0]  bit_q, bit_d;
    logic        err_flag_q, err_flag_d;

    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] otp_a_q, otp_a_d;
    logic        otp_csb_q, otp_csb_d;
    logic        otp_clk_q, otp_clk_d;
    logic        otp_re_q, otp_re_d;
    logic        otp_pgm_q, otp_pgm_d;
    logic [1:0]  otp_twlb_q, otp_sap_q;
    logic [3:0]  nb;

    // Lowest set bit of d at index >= from; 4'h8 when there is none.
    function automatic logic [3:0] next_bit(input logic [7:0] d, input logic [3:0] from);
        logic [3:0] r;
        r = 4'h8;
        for (int i = 7; i >= 0; i--) begin
            if (d[i] && (i >= int'(from))) r = 4'(i);
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        bit_d      = bit_q;
        err_flag_d = err_flag_q;
        nb         = 4'h8;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d     = addr;
                    we_d       = we;
                    wdata_d    = wdata;
                    err_flag_d = 1'b0;
                    state_d    = we ? S_PG_CHK : S_RD_SU;
                end
            end
            S_RD_SU: begin
                cnt_d   = CNT_W'(RD_WAIT - 1);
                state_d = S_RD_CLK;
            end
            S_RD_CLK: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_PG_CHK: begin
                nb = next_bit(wdata_q, 4'd0);
                if (!vpp_ok) begin
                    err_flag_d = 1'b1;
                    state_d    = S_DONE;
                end else if (nb[3]) begin
                    state_d = S_DONE;
                end else begin
                    bit_d   = nb[2:0];
                    state_d = S_PG_SU;
                end
            end
            S_PG_SU: begin
                if (!vpp_ok) err_flag_d = 1'b1;
                cnt_d   = CNT_W'(PG_PULSE - 1);
                state_d = S_PG_PULSE;
            end
            S_PG_PULSE: begin
                // A supply drop lets the current pulse finish; the gap then ends the op.
                if (!vpp_ok) err_flag_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(PG_GAP - 1);
                    state_d = S_PG_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PG_GAP: begin
                if (cnt_q == '0) begin
                    nb = next_bit(wdata_q, {1'b0, bit_q} + 4'd1);
                    if (err_flag_q || nb[3]) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d   = nb[2:0];
                        state_d = S_PG_SU;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin levels are decoded from the current state and registered.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        ack_d     = (state_q == S_DONE);
        err_d     = (state_q == S_DONE) && err_flag_q;
        rdata_d   = ((state_q == S_DONE) && !we_q) ? otp_q : rdata_q;
        otp_a_d   = otp_a_q;
        if (state_q == S_RD_SU) otp_a_d = {3'b000, addr_q};
        if (state_q == S_PG_SU) otp_a_d = {bit_q, addr_q};
        otp_csb_d = !(state_q inside {S_RD_SU, S_RD_CLK, S_PG_SU, S_PG_PULSE, S_PG_GAP});
        otp_re_d  = (state_q inside {S_RD_SU, S_RD_CLK});
        otp_pgm_d = (state_q inside {S_PG_SU, S_PG_PULSE});
        otp_clk_d = (state_q inside {S_RD_CLK, S_PG_PULSE});
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            bit_q      <= '0;
            err_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            otp_a_q    <= '0;
            otp_csb_q  <= 1'b1;
            otp_clk_q  <= 1'b0;
            otp_re_q   <= 1'b0;
            otp_pgm_q  <= 1'b0;
            otp_twlb_q <= '0;
            otp_sap_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            bit_q      <= bit_d;
            err_flag_q <= err_flag_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            otp_a_q    <= otp_a_d;
            otp_csb_q  <= otp_csb_d;
            otp_clk_q  <= otp_clk_d;
            otp_re_q   <= otp_re_d;
            otp_pgm_q  <= otp_pgm_d;
            otp_twlb_q <= twlb_cfg;
            otp_sap_q  <= sap_cfg;
        end
    end

    assign busy     = busy_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign otp_a    = otp_a_q;
    assign otp_csb  = otp_csb_q;
    assign otp_clk  = otp_clk_q;
    assign otp_re   = otp_re_q;
    assign otp_pgm  = otp_pgm_q;
    assign otp_twlb = otp_twlb_q;
    assign otp_sap  = otp_sap_q;

endmodule

// File: doc/otp_rw_ctrl.md
Name: otp_rw_ctrl

Overview:
Sequencer sitting directly upstream of the ATO0008KX8MX180LBX4DA 8Kx8 OTP macro; it converts a simple single-request byte read/program interface from the register/MCU bus into the macro's CSB/CLK/RE/PGM/A timing. Reads return one byte. Programs burn each '1' bit of the write byte individually with a timed PGM pulse. Timing is counter-based in clk cycles.

Parameters:
RD_WAIT, 4, clk cycles otp_clk is held high before Q is sampled (>=1)
PG_PULSE, 40, clk cycles otp_pgm/otp_clk held high per programmed bit (>=1)
PG_GAP, 4, idle clk cycles between bit pulses and after last pulse (>=1)
CNT_W, 8, width of the timing counter; must hold max(RD_WAIT, PG_PULSE, PG_GAP)

Ports:
clk  in  1  system clock
srst  in  1  synchronous reset, active high
req  in  1  request strobe, sampled only when busy=0
we  in  1  1=program, 0=read (qualified by req)
addr  in  13  byte address
wdata  in  8  bits to program (1=burn)
vpp_ok  in  1  VDDP supply ready; required for program
twlb_cfg  in  2  trim passed to otp_twlb
sap_cfg  in  2  trim passed to otp_sap
busy  out  1  operation in progress
ack  out  1  one-cycle completion pulse
rdata  out  8  read data, valid from ack, held until next read ack
err  out  1  one-cycle pulse with ack: program refused (vpp_ok=0)
otp_a  out  16  macro address: [12:0]=byte addr, [15:13]=bit index (program only, 0 on read)
otp_csb  out  1  macro chip select, active low
otp_clk  out  1  macro clock
otp_re  out  1  macro read enable
otp_pgm  out  1  macro program enable
otp_twlb  out  2  registered copy of twlb_cfg
otp_sap  out  2  registered copy of sap_cfg

Behaviour:
- One clock, clk; reset srst synchronous active-high. All outputs registered.
- Reset values: busy=0, ack=0, err=0, rdata=8'h00, otp_a=0, otp_csb=1, otp_clk=0, otp_re=0, otp_pgm=0, otp_twlb=0, otp_sap=0. srst mid-operation aborts immediately to IDLE with these values on the next edge; no ack.
- otp_twlb/otp_sap follow cfg inputs with one-cycle delay, always (including IDLE).
- addr/we/wdata latched on accepted req; later input changes ignored. req while busy=1 is dropped (no queue).
- States: IDLE, RD_SU, RD_CLK, PG_CHK, PG_SU, PG_PULSE, PG_GAP, DONE.
- IDLE: req=1 -> busy=1 next cycle; we=0 -> RD_SU; we=1 -> PG_CHK.
- RD_SU (1 cycle): otp_csb=0, otp_re=1, otp_a={3'b0,addr}. -> RD_CLK.
- RD_CLK: otp_clk=1 for RD_WAIT cycles; on last cycle Q sampled into rdata. -> DONE.
- PG_CHK (1 cycle): vpp_ok=0 -> DONE with err. vpp_ok=1 -> bit index b=0; skip to first b with wdata[b]=1; wdata=0 -> DONE with no pulses, no err.
- PG_SU (1 cycle): otp_csb=0, otp_pgm=1, otp_a={b,addr}. -> PG_PULSE.
- PG_PULSE: otp_clk=1 for PG_PULSE cycles. -> PG_GAP.
- PG_GAP: otp_clk=0, otp_pgm=0, otp_csb=0, for PG_GAP cycles; then next set bit above b -> PG_SU, else DONE.
- vpp_ok dropping during PG_SU/PG_PULSE: finish current pulse, enter PG_GAP, then DONE with err=1; remaining bits not burned.
- DONE (1 cycle): ack=1 (err per above), otp_csb=1, otp_re=0, otp_pgm=0, otp_clk=0, busy=0 same cycle; next req accepted the following cycle.
- Read latency req->ack = RD_WAIT+3 cycles. Program latency = 2 + n*(1+PG_PULSE+PG_GAP) + 1, n = popcount(wdata).
- otp_pgm and otp_re never high together; otp_clk never high while otp_csb=1.

Test Plan:
- Reset: drive mid-program srst=1 for 1 cycle -> next edge all outputs at reset values, no ack; subsequent read works.
- Read addr=13'h1A5, macro model Q=8'h3C -> otp_a=16'h01A5, otp_re=1, otp_clk high 4 cycles, ack at req+7 with rdata=8'h3C, err=0.
- Program addr=13'h0010, wdata=8'b1000_0101, vpp_ok=1 -> three pulses with otp_a=16'h0010, 16'h4010, 16'hE010, each otp_pgm high 41 cycles, ack at req+3+3*45, err=0.
- Program wdata=8'h00 -> no otp_pgm/otp_clk activity, ack 3 cycles after req, err=0.
- Program with vpp_ok=0 -> no pulses, ack+err pulse together; vpp_ok falling during 2nd of 3 bits -> 2 pulses total, ack+err.
- req held high continuously while busy and toggling addr -> only first request executed; next accepted the cycle after ack with its then-current addr.
